// File: rtl/i2c_target_regfile.sv
// I2C target with a 256-entry byte register file that responds like the ADV7511 configuration port.
// SCL and SDA are oversampled on clk_i. SDA is open-drain: the target either pulls it low or releases it.
// A transfer carries a 7-bit address, then one register-pointer byte, then auto-incrementing data bytes.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         NREGS    = 256,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o,
  input  logic [7:0] dbg_addr_i,
  output logic [7:0] dbg_data_o
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RD_MACK   = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  // Bit 0 is SCL and bit 1 is SDA. Both lines go through the same synchroniser and glitch filter.
  logic [1:0] raw_lvl;
  logic [1:0] filt_lvl;
  assign raw_lvl = {sda_i, scl_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      logic          s1_reg;
      logic          s2_reg;
      logic          lvl_reg;
      logic [CW-1:0] cnt_reg;

      // Synchronise the raw line with two flops.
      // The filtered level changes only after the synchronised level has differed from it for FILT_LEN cycles in a row.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          s1_reg  <= 1'b1;
          s2_reg  <= 1'b1;
          lvl_reg <= 1'b1;
          cnt_reg <= '0;
        end else begin
          s1_reg <= raw_lvl[gi];
          s2_reg <= s1_reg;
          if (s2_reg == lvl_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(FILT_LEN - 1)) begin
            lvl_reg <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end

      assign filt_lvl[gi] = lvl_reg;
    end
  endgenerate

  logic scl_f, sda_f;
  logic scl_prev_reg, sda_prev_reg, fall_d_reg;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_f     = filt_lvl[0];
  assign sda_f     = filt_lvl[1];
  assign scl_rise  = scl_f & ~scl_prev_reg;
  assign scl_fall  = ~scl_f & scl_prev_reg;
  assign start_det = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
  assign stop_det  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;

  // Keep the previous filtered levels for edge detection.
  // Also delay scl_fall by one cycle, so that SDA changes only on the cycle after an SCL falling edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      fall_d_reg   <= 1'b0;
    end else begin
      scl_prev_reg <= scl_f;
      sda_prev_reg <= sda_f;
      fall_d_reg   <= scl_fall;
    end
  end

  logic [3:0] state_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] ptr_reg;
  logic       rw_reg;
  logic       ack_low_reg;
  logic       mack_ok_reg;
  logic       sda_oe_reg;
  logic       busy_reg;
  logic       wr_valid_reg;
  logic [7:0] wr_addr_reg;
  logic [7:0] wr_data_reg;

  logic [7:0] reg_vals [NREGS];
  logic [7:0] byte_in;
  logic [7:0] rd_byte;
  logic [7:0] ptr_inc;
  logic       ptr_in_range;

  assign byte_in      = {shift_reg[6:0], sda_f};
  assign ptr_in_range = (32'(ptr_reg) < NREGS);
  assign rd_byte      = ptr_in_range ? reg_vals[ptr_reg] : 8'h00;
  assign ptr_inc      = (ptr_reg == 8'(NREGS - 1)) ? 8'd0 : ptr_reg + 8'd1;

  // Protocol FSM. START and STOP take priority in every state.
  // In the three *_ACK states, the first delayed fall pulls SDA low and the second one releases it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'h00;
      ptr_reg      <= 8'h00;
      rw_reg       <= 1'b0;
      ack_low_reg  <= 1'b0;
      mack_ok_reg  <= 1'b0;
      sda_oe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= 8'h00;
      wr_data_reg  <= 8'h00;
    end else begin
      wr_valid_reg <= 1'b0;
      if (stop_det) begin
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= 4'd0;
        ack_low_reg <= 1'b0;
        mack_ok_reg <= 1'b0;
        sda_oe_reg  <= 1'b0;
        busy_reg    <= 1'b0;
      end else if (start_det) begin
        state_reg   <= ST_ADDR;
        bit_cnt_reg <= 4'd0;
        ack_low_reg <= 1'b0;
        mack_ok_reg <= 1'b0;
        sda_oe_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg   <= byte_in;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_reg <= ST_ADDR_ACK;
                  rw_reg    <= byte_in[0];
                  busy_reg  <= 1'b1;
                end else begin
                  state_reg <= ST_IGNORE;
                end
              end
            end
          end
          ST_PTR: begin
            if (scl_rise) begin
              shift_reg   <= byte_in;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                ptr_reg   <= byte_in;
                state_reg <= ST_PTR_ACK;
              end
            end
          end
          ST_WDATA: begin
            if (scl_rise) begin
              shift_reg   <= byte_in;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                state_reg <= ST_WDATA_ACK;
                // Writes to a pointer outside the register file are still ACKed, but they are dropped here.
                if (ptr_in_range) begin
                  wr_valid_reg <= 1'b1;
                  wr_addr_reg  <= ptr_reg;
                  wr_data_reg  <= byte_in;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (fall_d_reg) begin
              if (!ack_low_reg) begin
                sda_oe_reg  <= 1'b1;
                ack_low_reg <= 1'b1;
              end else begin
                ack_low_reg <= 1'b0;
                bit_cnt_reg <= 4'd0;
                sda_oe_reg  <= 1'b0;
                if (state_reg == ST_ADDR_ACK) begin
                  if (rw_reg) begin
                    shift_reg  <= rd_byte;
                    sda_oe_reg <= ~rd_byte[7];
                    state_reg  <= ST_RDATA;
                  end else begin
                    state_reg <= ST_PTR;
                  end
                end else begin
                  state_reg <= ST_WDATA;
                  if (state_reg == ST_WDATA_ACK) begin
                    ptr_reg <= ptr_inc;
                  end
                end
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
            if (fall_d_reg) begin
              if (bit_cnt_reg == 4'd8) begin
                sda_oe_reg  <= 1'b0;
                mack_ok_reg <= 1'b0;
                state_reg   <= ST_RD_MACK;
              end else begin
                // Rotate rather than shift. The bit that wraps around is never driven.
                shift_reg  <= {shift_reg[6:0], shift_reg[7]};
                sda_oe_reg <= ~shift_reg[6];
              end
            end
          end
          ST_RD_MACK: begin
            // The pointer moves past every byte that was sent, whether the master ACKs or NACKs it.
            if (scl_rise) begin
              ptr_reg <= ptr_inc;
              if (!sda_f) begin
                mack_ok_reg <= 1'b1;
              end else begin
                state_reg <= ST_IGNORE;
              end
            end
            if (fall_d_reg && mack_ok_reg) begin
              mack_ok_reg <= 1'b0;
              shift_reg   <= rd_byte;
              sda_oe_reg  <= ~rd_byte[7];
              bit_cnt_reg <= 4'd0;
              state_reg   <= ST_RDATA;
            end
          end
          ST_IDLE, ST_IGNORE: begin
            sda_oe_reg <= 1'b0;
          end
          default: begin
            state_reg  <= ST_IDLE;
            sda_oe_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [7:0] val_reg;

      // Each register captures the delayed write strobe when its own index is addressed.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          val_reg <= 8'h00;
        end else if (wr_valid_reg && (wr_addr_reg == 8'(gi))) begin
          val_reg <= wr_data_reg;
        end
      end

      assign reg_vals[gi] = val_reg;
    end
  endgenerate

  assign sda_oe_o   = sda_oe_reg;
  assign busy_o     = busy_reg;
  assign wr_valid_o = wr_valid_reg;
  assign wr_addr_o  = wr_addr_reg;
  assign wr_data_o  = wr_data_reg;
  assign dbg_data_o = (32'(dbg_addr_i) < NREGS) ? reg_vals[dbg_addr_i] : 8'h00;

endmodule
